// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT address sequencer.
//   LOG2N_DEF   : default log2 of the transform size
//   MODE_DIF/DIT: values of the per-run addressing mode input
//   state_e     : sequencer FSM states
//   stage_width : width of the stage index for a given LOG2N
package fft_pkg;

    localparam int   LOG2N_DEF = 4;
    localparam logic MODE_DIF  = 1'b0;
    localparam logic MODE_DIT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Stage index width; never narrower than one bit.
    function automatic int stage_width(input int log2n);
        return (log2n <= 2) ? 1 : $clog2(log2n);
    endfunction

endpackage

// File: rtl/fft_addr_calc.sv
// Combinational butterfly address generator.
//   stage_i  : stage s of the butterfly
//   bfly_i   : butterfly index b within the stage (0 .. N/2-1)
//   mode_i   : 0 = DIF, 1 = DIT
//   a_addr_o : address of input A = (b / h) * 2h + (b mod h)
//   b_addr_o : address of input B = A + h
//   w_addr_o : twiddle exponent k of W_N^k
// h is 2^(L-1-s) for DIF and 2^s for DIT, so every division and
// modulo reduces to shifts and masks.
module fft_addr_calc
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int SW    = stage_width(LOG2N)
) (
    input  logic [SW-1:0]    stage_i,
    input  logic [LOG2N-2:0] bfly_i,
    input  logic             mode_i,
    output logic [LOG2N-1:0] a_addr_o,
    output logic [LOG2N-1:0] b_addr_o,
    output logic [LOG2N-2:0] w_addr_o
);

    localparam logic [SW-1:0] S_MAX = SW'(LOG2N - 1);

    logic [SW-1:0]    h_sh_s;   // log2(h)
    logic [SW-1:0]    w_sh_s;   // twiddle shift
    logic [LOG2N-1:0] h_s;
    logic [LOG2N-2:0] j_s;
    logic [LOG2N-1:0] hi_s;
    logic [LOG2N-1:0] a_s;

    // Pick the half-span exponent and twiddle shift for the addressing mode.
    always_comb begin
        if (mode_i == MODE_DIT) begin
            h_sh_s = stage_i;
            w_sh_s = S_MAX - stage_i;
        end else begin
            h_sh_s = S_MAX - stage_i;
            w_sh_s = stage_i;
        end
    end

    assign h_s  = LOG2N'(1'b1) << h_sh_s;
    // When h = N/2 its low LOG2N-1 bits are zero, so h-1 wraps to an
    // all-ones mask, which is exactly the b mod N/2 we need.
    assign j_s  = bfly_i & (h_s[LOG2N-2:0] - (LOG2N-1)'(1'b1));
    // (b / h) * h: b with its low log2(h) bits cleared.
    assign hi_s = ({1'b0, bfly_i} >> h_sh_s) << h_sh_s;
    assign a_s  = (hi_s << 1'b1) | {1'b0, j_s};

    assign a_addr_o = a_s;
    // Bit log2(h) of A is always clear, so OR is the same as A + h.
    assign b_addr_o = a_s | h_s;
    assign w_addr_o = j_s << w_sh_s;

endmodule

// File: rtl/fft_addr_seq.sv
// Radix-2 in-place FFT address sequencer.
// Steps through LOG2N stages of N/2 butterflies each and presents one
// registered beat per butterfly over a valid/ready handshake.
//   clk, rst_n        : rising-edge clock, async active-low reset
//   start             : begins a run from IDLE (mode sampled here)
//   mode              : 0 = DIF, 1 = DIT
//   abort             : synchronous run termination, no done pulse
//   addr_valid/ready  : beat handshake
//   stage, a_addr, b_addr, w_addr : beat payload
//   last_in_stage, last           : final butterfly of stage / of run
//   busy              : sequencer not idle
//   done              : one-cycle pulse after the final handshake
// STAGE_GAP idle cycles are inserted between consecutive stages.
module fft_addr_seq
    import fft_pkg::*;
#(
    parameter int LOG2N     = LOG2N_DEF,
    parameter int STAGE_GAP = 0,
    parameter int SW        = stage_width(LOG2N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic [SW-1:0]    stage,
    output logic [LOG2N-1:0] a_addr,
    output logic [LOG2N-1:0] b_addr,
    output logic [LOG2N-2:0] w_addr,
    output logic             last_in_stage,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam logic [SW-1:0]    S_LAST   = SW'(LOG2N - 1);
    localparam logic [LOG2N-2:0] B_LAST   = {(LOG2N-1){1'b1}};
    localparam logic [7:0]       GAP_LAST = (STAGE_GAP > 0) ? 8'(STAGE_GAP - 1) : 8'd0;

    state_e           state_q;
    logic             mode_q;
    logic [SW-1:0]    stage_q;   // stage of presented beat (of next beat in GAP)
    logic [LOG2N-2:0] bfly_q;
    logic [7:0]       gap_q;

    logic             valid_q;
    logic [SW-1:0]    stage_out_q;
    logic [LOG2N-1:0] a_q;
    logic [LOG2N-1:0] b_q;
    logic [LOG2N-2:0] w_q;
    logic             lis_q;
    logic             last_q;
    logic             done_q;

    logic             hs_s;
    logic             bfly_end_s;
    logic             run_end_s;
    logic [SW-1:0]    nxt_stage_s;
    logic [LOG2N-2:0] nxt_bfly_s;

    logic [SW-1:0]    beat_stage_d;
    logic [LOG2N-2:0] beat_bfly_d;
    logic             beat_mode_d;
    logic [LOG2N-1:0] beat_a_d;
    logic [LOG2N-1:0] beat_b_d;
    logic [LOG2N-2:0] beat_w_d;
    logic             beat_lis_d;
    logic             beat_last_d;

    assign hs_s        = valid_q & addr_ready;
    assign bfly_end_s  = (bfly_q == B_LAST);
    assign run_end_s   = bfly_end_s & (stage_q == S_LAST);
    assign nxt_bfly_s  = bfly_end_s ? {(LOG2N-1){1'b0}} : (bfly_q + (LOG2N-1)'(1'b1));
    assign nxt_stage_s = bfly_end_s ? (stage_q + SW'(1'b1)) : stage_q;

    // Select the indices of the beat that would be registered next.
    always_comb begin
        beat_stage_d = stage_q;
        beat_bfly_d  = bfly_q;
        beat_mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                beat_stage_d = {SW{1'b0}};
                beat_bfly_d  = {(LOG2N-1){1'b0}};
                beat_mode_d  = mode;
            end
            ST_RUN: begin
                beat_stage_d = nxt_stage_s;
                beat_bfly_d  = nxt_bfly_s;
                beat_mode_d  = mode_q;
            end
            ST_GAP: begin
                // counters were already advanced to the next stage's b=0
                beat_stage_d = stage_q;
                beat_bfly_d  = bfly_q;
                beat_mode_d  = mode_q;
            end
            default: begin
                beat_stage_d = stage_q;
                beat_bfly_d  = bfly_q;
                beat_mode_d  = mode_q;
            end
        endcase
    end

    assign beat_lis_d  = (beat_bfly_d == B_LAST);
    assign beat_last_d = beat_lis_d & (beat_stage_d == S_LAST);

    fft_addr_calc #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_calc (
        .stage_i  (beat_stage_d),
        .bfly_i   (beat_bfly_d),
        .mode_i   (beat_mode_d),
        .a_addr_o (beat_a_d),
        .b_addr_o (beat_b_d),
        .w_addr_o (beat_w_d)
    );

    // Sequencer FSM with registered beat outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            stage_q     <= {SW{1'b0}};
            bfly_q      <= {(LOG2N-1){1'b0}};
            gap_q       <= 8'd0;
            valid_q     <= 1'b0;
            stage_out_q <= {SW{1'b0}};
            a_q         <= {LOG2N{1'b0}};
            b_q         <= {LOG2N{1'b0}};
            w_q         <= {(LOG2N-1){1'b0}};
            lis_q       <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort && (state_q != ST_IDLE)) begin
            // abort beats a simultaneous handshake and suppresses done
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            stage_out_q <= {SW{1'b0}};
            a_q         <= {LOG2N{1'b0}};
            b_q         <= {LOG2N{1'b0}};
            w_q         <= {(LOG2N-1){1'b0}};
            lis_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        state_q     <= ST_RUN;
                        mode_q      <= mode;
                        stage_q     <= {SW{1'b0}};
                        bfly_q      <= {(LOG2N-1){1'b0}};
                        gap_q       <= 8'd0;
                        valid_q     <= 1'b1;
                        stage_out_q <= beat_stage_d;
                        a_q         <= beat_a_d;
                        b_q         <= beat_b_d;
                        w_q         <= beat_w_d;
                        lis_q       <= beat_lis_d;
                        last_q      <= beat_last_d;
                    end
                end
                ST_RUN: begin
                    if (hs_s) begin
                        if (run_end_s) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            stage_q <= nxt_stage_s;
                            bfly_q  <= nxt_bfly_s;
                            if (bfly_end_s && (STAGE_GAP > 0)) begin
                                state_q <= ST_GAP;
                                valid_q <= 1'b0;
                                gap_q   <= 8'd0;
                            end else begin
                                valid_q     <= 1'b1;
                                stage_out_q <= beat_stage_d;
                                a_q         <= beat_a_d;
                                b_q         <= beat_b_d;
                                w_q         <= beat_w_d;
                                lis_q       <= beat_lis_d;
                                last_q      <= beat_last_d;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q     <= ST_RUN;
                        valid_q     <= 1'b1;
                        stage_out_q <= beat_stage_d;
                        a_q         <= beat_a_d;
                        b_q         <= beat_b_d;
                        w_q         <= beat_w_d;
                        lis_q       <= beat_lis_d;
                        last_q      <= beat_last_d;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_valid    = valid_q;
    assign stage         = stage_out_q;
    assign a_addr        = a_q;
    assign b_addr        = b_q;
    assign w_addr        = w_q;
    assign last_in_stage = lis_q;
    assign last          = last_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_fft_addr_seq.sv
// Scoreboard bench for fft_addr_seq: three instances (16-point, 16-point
// with a 3-cycle stage gap, 64-point). Expected beats are pushed when a
// run is started; per-instance monitors pop and compare on handshakes.
module tb_fft_addr_seq;

    typedef struct {int s; int b; int a; int bb; int w; int lis; int last;} beat_t;
    typedef struct {int md; int s; int b; int a; int bb; int w; int last;} dir_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // instance 0: LOG2N=4, no gap
    logic       start0, mode0, abort0, rdy0, v0, lis0, last0, busy0, done0;
    logic [1:0] stage0;
    logic [3:0] a0, b0;
    logic [2:0] w0;
    // instance 1: LOG2N=4, STAGE_GAP=3
    logic       start1, mode1, abort1, rdy1, v1, lis1, last1, busy1, done1;
    logic [1:0] stage1;
    logic [3:0] a1, b1;
    logic [2:0] w1;
    // instance 2: LOG2N=6, no gap
    logic       start2, mode2, abort2, rdy2, v2, lis2, last2, busy2, done2;
    logic [2:0] stage2;
    logic [5:0] a2, b2;
    logic [4:0] w2;

    fft_addr_seq #(.LOG2N(4), .STAGE_GAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .abort(abort0),
        .addr_valid(v0), .addr_ready(rdy0), .stage(stage0), .a_addr(a0), .b_addr(b0),
        .w_addr(w0), .last_in_stage(lis0), .last(last0), .busy(busy0), .done(done0));

    fft_addr_seq #(.LOG2N(4), .STAGE_GAP(3)) dut_gap (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .abort(abort1),
        .addr_valid(v1), .addr_ready(rdy1), .stage(stage1), .a_addr(a1), .b_addr(b1),
        .w_addr(w1), .last_in_stage(lis1), .last(last1), .busy(busy1), .done(done1));

    fft_addr_seq #(.LOG2N(6), .STAGE_GAP(0)) dut_l6 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .abort(abort2),
        .addr_valid(v2), .addr_ready(rdy2), .stage(stage2), .a_addr(a2), .b_addr(b2),
        .w_addr(w2), .last_in_stage(lis2), .last(last2), .busy(busy2), .done(done2));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Golden beat from the textbook formulas (division/modulo/powers).
    function automatic beat_t model(input int L, input int md, input int s, input int b);
        beat_t r;
        int h;
        h      = (md == 0) ? 2 ** (L - 1 - s) : 2 ** s;
        r.s    = s;
        r.b    = b;
        r.a    = (b / h) * 2 * h + (b % h);
        r.bb   = r.a + h;
        r.w    = (md == 0) ? (b % h) * (2 ** s) : (b % h) * (2 ** (L - 1 - s));
        r.lis  = (b == 2 ** (L - 1) - 1) ? 1 : 0;
        r.last = (r.lis == 1 && s == L - 1) ? 1 : 0;
        return r;
    endfunction

    task automatic cmp_beat(input string tag, input beat_t e, input int s, input int a,
                            input int bb, input int w, input int lis, input int last);
        chk($sformatf("%s_s%0db%0d_stage", tag, e.s, e.b), s, e.s);
        chk($sformatf("%s_s%0db%0d_a", tag, e.s, e.b), a, e.a);
        chk($sformatf("%s_s%0db%0d_b", tag, e.s, e.b), bb, e.bb);
        chk($sformatf("%s_s%0db%0d_w", tag, e.s, e.b), w, e.w);
        chk($sformatf("%s_s%0db%0d_lis", tag, e.s, e.b), lis, e.lis);
        chk($sformatf("%s_s%0db%0d_last", tag, e.s, e.b), last, e.last);
    endtask

    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];
    dir_t  dir_tab [8];
    int    dir_hit [8];
    int    cur_mode0 = 0;

    task automatic push0(input int md);
        for (int s = 0; s < 4; s++)
            for (int b = 0; b < 8; b++)
                q0.push_back(model(4, md, s, b));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor for instance 0 ----------------
    beat_t      e0;
    int         hold0 = 0;
    int         done_exp0 = 0;
    logic [1:0] h_stage0;
    logic [3:0] h_a0, h_b0;
    logic [2:0] h_w0;
    logic       h_lis0, h_last0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold0     = 0;
            done_exp0 = 0;
        end else begin
            if (hold0 != 0) begin
                chk("hold_valid", int'(v0), 1);
                chk("hold_stage", int'(stage0), int'(h_stage0));
                chk("hold_a", int'(a0), int'(h_a0));
                chk("hold_b", int'(b0), int'(h_b0));
                chk("hold_w", int'(w0), int'(h_w0));
                chk("hold_lis", int'(lis0), int'(h_lis0));
                chk("hold_last", int'(last0), int'(h_last0));
            end
            if (done_exp0 != 0) chk("done_after_last", int'(done0), 1);
            else                chk("done_quiet", int'(done0), 0);
            done_exp0 = 0;
            if (v0 && rdy0 && !abort0) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb0_extra_beat: actual stage=%0d a=%0d required=no beat", stage0, a0);
                end else begin
                    e0 = q0.pop_front();
                    cmp_beat("u0", e0, int'(stage0), int'(a0), int'(b0), int'(w0), int'(lis0), int'(last0));
                    for (int i = 0; i < 8; i++) begin
                        if (dir_tab[i].md == cur_mode0 && dir_tab[i].s == e0.s && dir_tab[i].b == e0.b) begin
                            chk($sformatf("dir%0d_a", i), int'(a0), dir_tab[i].a);
                            chk($sformatf("dir%0d_b", i), int'(b0), dir_tab[i].bb);
                            chk($sformatf("dir%0d_w", i), int'(w0), dir_tab[i].w);
                            chk($sformatf("dir%0d_last", i), int'(last0), dir_tab[i].last);
                            dir_hit[i] = 1;
                        end
                    end
                    done_exp0 = e0.last;
                end
            end
            hold0    = (v0 && !rdy0 && !abort0) ? 1 : 0;
            h_stage0 = stage0;
            h_a0     = a0;
            h_b0     = b0;
            h_w0     = w0;
            h_lis0   = lis0;
            h_last0  = last0;
        end
    end

    // ---------------- monitor for instance 1 (stage gap) ----------------
    beat_t e1;
    int    gap1 = 0;
    int    gaps_seen1 = 0;
    int    lis_hs1 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (v1 && gap1 > 0) begin
                chk("gap_len", gap1, 3);
                chk("gap_after_lis", lis_hs1, 1);
                gaps_seen1++;
                gap1 = 0;
            end
            if (done1) chk("gap_before_done", gap1, 0);
            if (busy1 && !v1 && !done1) gap1++;
            if (v1 && rdy1) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb1_extra_beat: actual stage=%0d a=%0d required=no beat", stage1, a1);
                end else begin
                    e1 = q1.pop_front();
                    cmp_beat("u1", e1, int'(stage1), int'(a1), int'(b1), int'(w1), int'(lis1), int'(last1));
                    lis_hs1 = e1.lis;
                end
            end
        end
    end

    // ---------------- monitor for instance 2 (64-point) ----------------
    beat_t e2;
    int    hit2 = 0;

    always @(negedge clk) begin
        if (rst_n && v2 && rdy2) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb2_extra_beat: actual stage=%0d a=%0d required=no beat", stage2, a2);
            end else begin
                e2 = q2.pop_front();
                cmp_beat("u2", e2, int'(stage2), int'(a2), int'(b2), int'(w2), int'(lis2), int'(last2));
                if (e2.s == 2 && e2.b == 9) begin
                    chk("l6_s2b9_a", int'(a2), 17);
                    chk("l6_s2b9_b", int'(b2), 25);
                    chk("l6_s2b9_w", int'(w2), 4);
                    hit2 = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n;
        // hand-computed beats for 16-point runs: mode, s, b, A, B, W, last
        dir_tab[0] = '{0, 0, 0, 0, 8, 0, 0};
        dir_tab[1] = '{0, 0, 1, 1, 9, 1, 0};
        dir_tab[2] = '{0, 1, 1, 1, 5, 2, 0};
        dir_tab[3] = '{0, 1, 4, 8, 12, 0, 0};
        dir_tab[4] = '{0, 3, 7, 14, 15, 0, 1};
        dir_tab[5] = '{1, 0, 1, 2, 3, 0, 0};
        dir_tab[6] = '{1, 1, 3, 5, 7, 4, 0};
        dir_tab[7] = '{1, 3, 5, 5, 13, 5, 0};
        for (int i = 0; i < 8; i++) dir_hit[i] = 0;

        rst_n = 1'b0;
        start0 = 1'b0; mode0 = 1'b0; abort0 = 1'b0; rdy0 = 1'b1;
        start1 = 1'b0; mode1 = 1'b0; abort1 = 1'b0; rdy1 = 1'b1;
        start2 = 1'b0; mode2 = 1'b0; abort2 = 1'b0; rdy2 = 1'b1;
        step(2);
        chk("rst_valid", int'(v0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_stage", int'(stage0), 0);
        chk("rst_a", int'(a0), 0);
        chk("rst_b", int'(b0), 0);
        chk("rst_w", int'(w0), 0);
        chk("rst_lis", int'(lis0), 0);
        chk("rst_last", int'(last0), 0);
        rst_n = 1'b1;
        step(2);

        // DIF, ready=1, with a start pulse mid-run that must be ignored
        cur_mode0 = 0;
        push0(0);
        start0 = 1'b1;
        n = 0;
        do begin
            step(1);
            start0 = (n == 9) ? 1'b1 : 1'b0;
            n++;
        end while (!done0 && n < 200);
        chk("dif_run_len", n, 33);
        start0 = 1'b1;              // during the DONE cycle
        step(1);
        start0 = 1'b0;
        chk("start_in_done_busy", int'(busy0), 0);
        chk("start_in_done_valid", int'(v0), 0);
        step(2);
        chk("idle_after_done_valid", int'(v0), 0);
        chk("sb0_drained_dif", q0.size(), 0);

        // DIT with the mode input toggling throughout the run
        cur_mode0 = 1;
        push0(1);
        mode0 = 1'b1;
        start0 = 1'b1;
        n = 0;
        do begin
            step(1);
            start0 = 1'b0;
            mode0 = ~mode0;
            n++;
        end while (!done0 && n < 200);
        chk("dit_run_len", n, 33);
        mode0 = 1'b0;
        step(2);
        chk("sb0_drained_dit", q0.size(), 0);

        // DIF under random backpressure
        cur_mode0 = 0;
        push0(0);
        start0 = 1'b1;
        n = 0;
        do begin
            step(1);
            start0 = 1'b0;
            rdy0 = 1'($urandom_range(0, 1));
            n++;
        end while (!done0 && n < 2000);
        rdy0 = 1'b1;
        chk("bp_done_seen", int'(done0), 1);
        step(2);
        chk("sb0_drained_bp", q0.size(), 0);

        // abort while beat (s2,b3) is presented with ready=1
        push0(0);
        start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        n = 0;
        while (!(v0 && stage0 == 2'd2 && a0 == 4'd5) && n < 100) begin
            step(1);
            n++;
        end
        chk("abort_target_seen", (v0 && stage0 == 2'd2 && a0 == 4'd5) ? 1 : 0, 1);
        abort0 = 1'b1;
        step(1);
        abort0 = 1'b0;
        chk("abort_valid", int'(v0), 0);
        chk("abort_busy", int'(busy0), 0);
        chk("abort_done", int'(done0), 0);
        chk("abort_beats_left", q0.size(), 13);
        q0.delete();
        step(3);
        chk("abort_idle_valid", int'(v0), 0);
        // start together with abort in IDLE: no run
        start0 = 1'b1;
        abort0 = 1'b1;
        step(1);
        start0 = 1'b0;
        abort0 = 1'b0;
        chk("start_abort_busy", int'(busy0), 0);
        chk("start_abort_valid", int'(v0), 0);
        step(2);
        // restart from (s0,b0)
        push0(0);
        start0 = 1'b1;
        n = 0;
        do begin
            step(1);
            start0 = 1'b0;
            n++;
        end while (!done0 && n < 200);
        chk("restart_run_len", n, 33);
        step(2);
        chk("sb0_drained_restart", q0.size(), 0);

        // asynchronous reset in the middle of a run
        push0(0);
        start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(v0), 0);
        chk("arst_busy", int'(busy0), 0);
        chk("arst_stage", int'(stage0), 0);
        chk("arst_a", int'(a0), 0);
        chk("arst_b", int'(b0), 0);
        chk("arst_w", int'(w0), 0);
        q0.delete();
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("arst_after_valid", int'(v0), 0);
        chk("arst_after_done", int'(done0), 0);

        // stage gap of 3 cycles
        for (int s = 0; s < 4; s++)
            for (int b = 0; b < 8; b++)
                q1.push_back(model(4, 0, s, b));
        start1 = 1'b1;
        n = 0;
        do begin
            step(1);
            start1 = 1'b0;
            n++;
        end while (!done1 && n < 300);
        chk("gap_run_len", n, 42);
        step(2);
        chk("gap_count", gaps_seen1, 3);
        chk("sb1_drained", q1.size(), 0);

        // 64-point DIF
        for (int s = 0; s < 6; s++)
            for (int b = 0; b < 32; b++)
                q2.push_back(model(6, 0, s, b));
        start2 = 1'b1;
        n = 0;
        do begin
            step(1);
            start2 = 1'b0;
            n++;
        end while (!done2 && n < 600);
        chk("l6_run_len", n, 193);
        step(2);
        chk("sb2_drained", q2.size(), 0);
        chk("l6_spot_hit", hit2, 1);

        for (int i = 0; i < 8; i++) chk($sformatf("dir%0d_hit", i), dir_hit[i], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_addr_seq.md
Name: fft_addr_seq

Overview:
Parametrised sequencer for an in-place radix-2 FFT engine. It steps through all stages and butterflies of an N = 2^LOG2N point transform. For each butterfly it emits one registered beat: the A/B memory addresses and the twiddle index, over a valid/ready handshake. It supports DIF and DIT addressing, selected per run, and an optional idle gap between stages so the butterfly pipeline can drain. It sits between the FFT control FSM and the data RAM / twiddle ROM.

Parameters:
LOG2N, 4, log2 of transform size; legal range 2..12 (default gives 16-point).
STAGE_GAP, 0, idle cycles inserted between consecutive stages; legal range 0..255.
SW, $clog2(LOG2N), stage index width; derived, not overridden.

Ports:
clk  in  1  clock; all logic rising-edge.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  pulse; begins a run when in IDLE, ignored otherwise.
mode  in  1  0 = DIF, 1 = DIT; sampled only on an accepted start.
abort  in  1  synchronous; terminates a run.
addr_valid  out  1  beat outputs are valid.
addr_ready  in  1  consumer accepts the beat.
stage  out  SW  stage of the current beat.
a_addr  out  LOG2N  address of butterfly input A.
b_addr  out  LOG2N  address of butterfly input B.
w_addr  out  LOG2N-1  twiddle index (exponent k of W_N^k).
last_in_stage  out  1  beat is the final butterfly of its stage.
last  out  1  beat is the final butterfly of the run.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse at run completion.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; latched mode 0.
- FSM states: IDLE, RUN, GAP, DONE.
  - IDLE: start=1 → RUN. Mode is latched, counters are cleared, and beat (s=0, b=0) is registered, so addr_valid=1 the cycle after start.
  - RUN: a handshake is addr_valid&addr_ready. On a handshake, b increments.
    - b wraps from N/2-1 to 0 at stage end. s then increments: to GAP if STAGE_GAP>0, else directly to the next beat.
    - A handshake on the final beat (s=LOG2N-1, b=N/2-1) → DONE.
  - GAP: addr_valid=0 for exactly STAGE_GAP cycles, then RUN with the next stage's b=0 beat.
  - DONE: addr_valid=0, done=1 for one cycle → IDLE.
- Without a handshake, all beat outputs hold stable (AXI-style). addr_valid never drops without a handshake except on abort or reset.
- Address math, with L=LOG2N, s=stage, b=butterfly:
  - DIF: h=2^(L-1-s), W=j<<s.
  - DIT: h=2^s, W=j<<(L-1-s).
  - Common: j=b mod h, g=b/h, A=g*2h+j, B=A+h.
  - All results fit unsigned in the port widths; no truncation.
- Flags: last_in_stage = (b==N/2-1); last = last_in_stage & (s==L-1). Both are registered alongside the beat.
- Throughput: one beat per cycle under continuous ready. Total beats = L*N/2.
- Run length with ready=1 from start: L*N/2 + (L-1)*STAGE_GAP RUN/GAP cycles, plus the DONE cycle.
- start while busy (including the DONE cycle): ignored.
- abort: in any non-IDLE state, go to IDLE next cycle. addr_valid=0 and done stays 0. abort wins over a simultaneous handshake. abort in IDLE does nothing. start and abort together in IDLE: abort wins, no run.
- Asynchronous reset mid-run: immediate return to the reset values; no done.

Decomposition:
- fft_pkg: LOG2N default, MODE_DIF/MODE_DIT constants, state enum, stage-width function.
- Sub-module fft_addr_calc: purely combinational (stage, bfly, mode) → a_addr, b_addr, w_addr, parametrised by LOG2N. The sequencer registers its outputs.

Test Plan:
- LOG2N=4, DIF, ready=1: beats (s0,b0) A0/B8/W0; (s0,b1) A1/B9/W1; (s1,b1) A1/B5/W2; (s1,b4) A8/B12/W0; (s3,b7) A14/B15/W0 with last=1. Expect 32 beats and done exactly one cycle after the last handshake.
- LOG2N=4, DIT: (s0,b1) A2/B3/W0; (s1,b3) A5/B7/W4; (s3,b5) A5/B13/W5. Mode is held even if the mode input toggles mid-run.
- Backpressure, random addr_ready at 50%: outputs stable while valid & !ready. The sequence matches a golden model beat for beat, with no drops or duplicates.
- STAGE_GAP=3: exactly 3 cycles of addr_valid=0 after each last_in_stage handshake, none after the final one; total 32+9 beats-plus-gap cycles.
- abort at (s2,b3) together with ready=1: next cycle IDLE, valid=0, done never asserts. A restart then begins at (s0,b0). start pulsed during RUN and during DONE is ignored.
- LOG2N=6, DIF, spot check: (s2,b9) A17/B25/W4. rst_n dropped mid-run clears all outputs asynchronously, without waiting for a clk edge.
